// File: rtl/pulse_train_pkg.sv
// Shared types and config normalisation for the pulse-train controller.
package pulse_train_pkg;

  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {IDLE, RUN_HI, RUN_LO, DONE} state_t;

  // A period shorter than 2 cycles cannot hold both a high and a low phase.
  function automatic int unsigned norm_period(input int unsigned period);
    return (period < 2) ? 2 : period;
  endfunction

  // Expects an already-normalised period; keeps at least one low cycle.
  function automatic int unsigned norm_high(input int unsigned period, input int unsigned high);
    int unsigned h;
    h = (high == 0) ? 1 : high;
    return (h >= period) ? period - 1 : h;
  endfunction

endpackage

// File: rtl/pulse_train_ctrl_phase_cnt.sv
// Loadable down-counter timing one HI or LO phase; tc_c flags the last cycle.
module pulse_phase_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_ctrl.sv
// Pulse-train controller: config shadow regs, HI/LO sequencing FSM, burst counting.
module pulse_train_ctrl
  import pulse_train_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DEF_PERIOD = 5,
  parameter int unsigned DEF_HIGH   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_idx
);

  state_t           state_q, state_d;
  logic             stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0] period_q, high_q, count_q;
  logic [CNT_W-1:0] period_n, high_n, start_high;
  logic             cfg_acc;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             phase_tc;
  logic             last_pulse;

  assign cfg_acc    = cfg_valid && cfg_ready;
  assign period_n   = CNT_W'(norm_period(32'(cfg_period)));
  assign high_n     = CNT_W'(norm_high(32'(period_n), 32'(cfg_high)));
  // A config accepted alongside start must govern the very first high phase.
  assign start_high = cfg_acc ? high_n : high_q;
  assign last_pulse = (count_q != '0) && (pulse_idx == count_q);

  pulse_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc_c     (phase_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN_HI;
          cnt_load = 1'b1;
          cnt_val  = start_high - CNT_W'(1);
        end
      end
      RUN_HI: begin
        if (stop) stop_pend_d = 1'b1;
        if (phase_tc) begin
          state_d  = RUN_LO;
          cnt_load = 1'b1;
          cnt_val  = period_q - high_q - CNT_W'(1);
        end
      end
      RUN_LO: begin
        if (stop) stop_pend_d = 1'b1;
        if (phase_tc) begin
          if (last_pulse || stop_pend_d) begin
            state_d = DONE;
          end else begin
            state_d  = RUN_HI;
            cnt_load = 1'b1;
            cnt_val  = high_q - CNT_W'(1);
          end
        end
      end
      DONE: begin
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q  <= CNT_W'(DEF_PERIOD);
      high_q    <= CNT_W'(DEF_HIGH);
      count_q   <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
      pulse_idx <= '0;
    end else begin
      if (cfg_acc) begin
        period_q <= period_n;
        high_q   <= high_n;
        count_q  <= cfg_count;
      end
      pulse_out <= (state_d == RUN_HI);
      busy      <= (state_d == RUN_HI) || (state_d == RUN_LO);
      done      <= (state_d == DONE);
      cfg_ready <= (state_d == IDLE);
      if (state_d == RUN_HI && state_q != RUN_HI) begin
        pulse_idx <= (state_q == IDLE) ? CNT_W'(1) : pulse_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Self-checking bench for pulse_train_ctrl: vector table of bursts plus reset corner cases.
module tb_pulse_train_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_count;
  logic             start;
  logic             stop;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_idx;

  int n_tests;
  int n_fail;

  typedef struct {
    logic             pulse;
    logic             busy;
    logic             done;
    logic             rdy;
    logic [CNT_W-1:0] idx;
  } exp_t;

  typedef struct {
    bit use_cfg;
    bit same_cycle;
    int cp;
    int ch;
    int cc;
    int ep;
    int eh;
    int stop_at;
    int busy_start_at;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  pulse_train_ctrl #(.CNT_W(CNT_W), .DEF_PERIOD(5), .DEF_HIGH(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_count  (cfg_count),
    .start      (start),
    .stop       (stop),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .pulse_idx  (pulse_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, " pulse_out"}, 32'(pulse_out), 32'(e.pulse));
    check({tag, " busy"}, 32'(busy), 32'(e.busy));
    check({tag, " done"}, 32'(done), 32'(e.done));
    check({tag, " cfg_ready"}, 32'(cfg_ready), 32'(e.rdy));
    check({tag, " pulse_idx"}, 32'(pulse_idx), 32'(e.idx));
  endtask

  function automatic vec_t mk(input bit use_cfg, input bit same, input int cp, input int ch,
                              input int cc, input int ep, input int eh, input int stop_at,
                              input int busy_start_at);
    vec_t v;
    v.use_cfg = use_cfg; v.same_cycle = same;
    v.cp = cp; v.ch = ch; v.cc = cc; v.ep = ep; v.eh = eh;
    v.stop_at = stop_at; v.busy_start_at = busy_start_at;
    return v;
  endfunction

  // Expected cycle j after start: pulses of period p, high h, n pulses, then DONE, then IDLE.
  function automatic exp_t expect_cycle(input int j, input int p, input int h, input int n);
    exp_t e;
    if (j < n * p) begin
      e.pulse = ((j % p) < h); e.busy = 1'b1; e.done = 1'b0; e.rdy = 1'b0;
      e.idx = CNT_W'(j / p + 1);
    end else begin
      e.pulse = 1'b0; e.busy = 1'b0; e.done = (j == n * p); e.rdy = (j != n * p);
      e.idx = CNT_W'(n);
    end
    return e;
  endfunction

  task automatic run_vec(input vec_t v, input int vid);
    int n;
    int total;
    exp_t e;
    @(negedge clk);
    if (v.use_cfg) begin
      cfg_valid  = 1'b1;
      cfg_period = CNT_W'(v.cp);
      cfg_high   = CNT_W'(v.ch);
      cfg_count  = CNT_W'(v.cc);
      check($sformatf("v%0d cfg_ready idle", vid), 32'(cfg_ready), 32'd1);
      if (!v.same_cycle) begin
        @(negedge clk);
        cfg_valid = 1'b0;
      end
    end
    start = 1'b1;
    n = v.cc;
    if (v.stop_at >= 0) begin
      if (n == 0 || (v.stop_at / v.ep + 1) < n) n = v.stop_at / v.ep + 1;
    end
    total = n * v.ep + 2;
    for (int j = 0; j < total; j++) sb.push_back(expect_cycle(j, v.ep, v.eh, n));
    for (int j = 0; j < total; j++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      start = (j == v.busy_start_at);
      stop  = (j == v.stop_at);
      e = sb.pop_front();
      check_outputs($sformatf("v%0d c%0d", vid, j), e);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    exp_t rst_e;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0; cfg_count = '0;
    start = 1'b0; stop = 1'b0;

    vecs[0] = mk(0, 0, 0, 0, 0, 5, 1, 17, -1);  // defaults, continuous, stopped in pulse 4
    vecs[1] = mk(1, 0, 8, 3, 4, 8, 3, -1, -1);
    vecs[2] = mk(1, 0, 1, 0, 3, 2, 1, -1, -1);  // period/high clamp up
    vecs[3] = mk(1, 0, 6, 9, 2, 6, 5, -1, -1);  // high clamped to period-1
    vecs[4] = mk(1, 0, 6, 3, 0, 6, 3, 13, -1);  // stop mid-RUN_HI of pulse 3
    vecs[5] = mk(1, 1, 4, 2, 3, 4, 2, -1, 2);   // cfg with start; start while busy
    vecs[6] = mk(1, 0, 4, 1, 2, 4, 1, 5, -1);   // stop during final pulse
    vecs[7] = mk(1, 0, 5, 5, 1, 5, 4, -1, -1);  // high == period

    rst_e.pulse = 1'b0; rst_e.busy = 1'b0; rst_e.done = 1'b0; rst_e.rdy = 1'b1; rst_e.idx = '0;
    repeat (2) @(negedge clk);
    check_outputs("reset", rst_e);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset during RUN_HI aborts with no done strobe and restores default timing.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrst pre pulse_out", 32'(pulse_out), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_outputs("midrst", rst_e);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_outputs($sformatf("midrst idle%0d", k), rst_e);
    end
    run_vec(vecs[0], 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
